// File: rtl/ram_sum_ctrl.sv
// ram_sum_ctrl: sums LEN consecutive RAM words starting at SRC.
// Writes the sum back to DST and reports it on sum with a done pulse.
module ram_sum_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [ADDR_WIDTH:0]   len,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] sum,
  output logic                  overflow,
  output logic [ADDR_WIDTH-1:0] ram_read_addr,
  output logic [ADDR_WIDTH-1:0] ram_write_addr,
  output logic                  ram_we,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_q
);

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    DRAIN,
    WRITE,
    DONE
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] src_l;
  logic [ADDR_WIDTH-1:0] dst_l;
  logic [ADDR_WIDTH:0]   len_l;
  logic [ADDR_WIDTH:0]   cnt;
  logic [DATA_WIDTH-1:0] acc;
  logic                  carry_seen;
  logic [1:0]            vld;
  logic [DATA_WIDTH:0]   acc_next;

  // Widened add so the carry out of the accumulator is visible.
  always_comb begin
    acc_next = {1'b0, acc} + {1'b0, ram_q};
  end

  // Control FSM plus the two-stage read-valid pipeline feeding the accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      src_l          <= '0;
      dst_l          <= '0;
      len_l          <= '0;
      cnt            <= '0;
      acc            <= '0;
      carry_seen     <= 1'b0;
      vld            <= 2'b00;
      busy           <= 1'b0;
      done           <= 1'b0;
      sum            <= '0;
      overflow       <= 1'b0;
      ram_read_addr  <= '0;
      ram_write_addr <= '0;
      ram_we         <= 1'b0;
      ram_wdata      <= '0;
    end else begin
      done <= 1'b0;
      vld  <= {vld[0], 1'b0};
      if (vld[1]) begin
        acc <= acc_next[DATA_WIDTH-1:0];
        if (acc_next[DATA_WIDTH]) carry_seen <= 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (start && !busy && !done) begin
            src_l      <= src_addr;
            dst_l      <= dst_addr;
            len_l      <= len;
            acc        <= '0;
            carry_seen <= 1'b0;
            if (len != '0) begin
              ram_read_addr <= src_addr;
              cnt           <= {{ADDR_WIDTH{1'b0}}, 1'b1};
              vld[0]        <= 1'b1;
              busy          <= 1'b1;
              state         <= RUN;
            end else begin
              cnt   <= '0;
              state <= DONE;
            end
          end
        end
        RUN: begin
          if (cnt == len_l) begin
            state <= DRAIN;
          end else begin
            ram_read_addr <= src_l + cnt[ADDR_WIDTH-1:0];
            cnt           <= cnt + 1'b1;
            vld[0]        <= 1'b1;
          end
        end
        DRAIN: begin
          // Last word is accumulated on this edge.
          if (vld[1] && !vld[0]) state <= WRITE;
        end
        WRITE: begin
          ram_we         <= 1'b1;
          ram_write_addr <= dst_l;
          ram_wdata      <= acc;
          state          <= DONE;
        end
        DONE: begin
          ram_we   <= 1'b0;
          done     <= 1'b1;
          busy     <= 1'b0;
          sum      <= acc;
          overflow <= carry_seen;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_sum_ctrl.sv
// tb_ram_sum_ctrl: directed bench for ram_sum_ctrl.
// Includes a 1-cycle-read dual-port RAM model preloaded per scenario.
module tb_ram_sum_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [3:0]  src_addr;
  logic [4:0]  len;
  logic [3:0]  dst_addr;
  logic        busy;
  logic        done;
  logic [31:0] sum;
  logic        overflow;
  logic [3:0]  ram_read_addr;
  logic [3:0]  ram_write_addr;
  logic        ram_we;
  logic [31:0] ram_wdata;
  logic [31:0] ram_q;

  logic [31:0] mem [16];
  logic [31:0] init_mem [16];
  logic        reload;

  int total;
  int bad;
  int busy_cnt;
  int done_cnt;
  int we_cnt;
  int done_k;
  int n_addr;
  logic [3:0] addrs [32];

  ram_sum_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .src_addr(src_addr),
    .len(len),
    .dst_addr(dst_addr),
    .busy(busy),
    .done(done),
    .sum(sum),
    .overflow(overflow),
    .ram_read_addr(ram_read_addr),
    .ram_write_addr(ram_write_addr),
    .ram_we(ram_we),
    .ram_wdata(ram_wdata),
    .ram_q(ram_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reload) begin
      for (int i = 0; i < 16; i++) mem[i] <= init_mem[i];
    end else if (ram_we) begin
      mem[ram_write_addr] <= ram_wdata;
    end
    ram_q <= mem[ram_read_addr];
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [31:0] w0, input logic [31:0] w1);
    for (int i = 0; i < 16; i++) init_mem[i] = 32'(i + 1);
    init_mem[0] = w0;
    init_mem[1] = w1;
    @(negedge clk);
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
  endtask

  task automatic run_op(input logic [3:0] s, input logic [4:0] l,
                        input logic [3:0] d, input int restart_k);
    busy_cnt = 0;
    done_cnt = 0;
    we_cnt   = 0;
    done_k   = -1;
    n_addr   = 0;
    @(negedge clk);
    src_addr = s;
    len      = l;
    dst_addr = d;
    start    = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      start = (k + 1 == restart_k);
      if (k + 1 == restart_k) begin
        src_addr = 4'd5;
        len      = 5'd1;
        dst_addr = 4'd3;
      end
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        done_k = k;
      end
      if (ram_we) we_cnt++;
      if (busy && k < int'(l) && n_addr < 32) begin
        addrs[n_addr] = ram_read_addr;
        n_addr++;
      end
      if (done_k >= 0 && k >= done_k + 2) break;
    end
    start = 1'b0;
    chk("done_seen", 64'(done_k >= 0), 64'd1);
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    reload   = 1'b0;
    rst_n    = 1'b0;
    start    = 1'b0;
    src_addr = '0;
    len      = '0;
    dst_addr = '0;
    load(32'h1, 32'h2);
    #2;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_sum", 64'(sum), 64'd0);
    chk("rst_we", 64'(ram_we), 64'd0);
    chk("rst_raddr", 64'(ram_read_addr), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(4'd0, 5'd4, 4'd15, -1);
    chk("s1_sum", 64'(sum), 64'h0A);
    chk("s1_mem15", 64'(mem[15]), 64'h0A);
    chk("s1_busy", 64'(busy_cnt), 64'd7);
    chk("s1_done_cnt", 64'(done_cnt), 64'd1);
    chk("s1_done_edge", 64'(done_k), 64'd7);
    chk("s1_ovf", 64'(overflow), 64'd0);
    chk("s1_we_cnt", 64'(we_cnt), 64'd1);

    load(32'h1, 32'h2);
    run_op(4'd14, 5'd4, 4'd8, -1);
    chk("s2_sum", 64'(sum), 64'h22);
    chk("s2_mem8", 64'(mem[8]), 64'h22);
    chk("s2_n_addr", 64'(n_addr), 64'd4);
    chk("s2_a0", 64'(addrs[0]), 64'd14);
    chk("s2_a1", 64'(addrs[1]), 64'd15);
    chk("s2_a2", 64'(addrs[2]), 64'd0);
    chk("s2_a3", 64'(addrs[3]), 64'd1);

    load(32'h1, 32'h2);
    run_op(4'd3, 5'd0, 4'd5, -1);
    chk("s3_done_edge", 64'(done_k), 64'd1);
    chk("s3_sum", 64'(sum), 64'd0);
    chk("s3_busy", 64'(busy_cnt), 64'd0);
    chk("s3_we_cnt", 64'(we_cnt), 64'd0);
    chk("s3_mem5", 64'(mem[5]), 64'd6);

    load(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(4'd0, 5'd2, 4'd2, -1);
    chk("s4_sum", 64'(sum), 64'hFFFF_FFFE);
    chk("s4_ovf", 64'(overflow), 64'd1);
    chk("s4_mem2", 64'(mem[2]), 64'hFFFF_FFFE);
    run_op(4'd4, 5'd1, 4'd9, -1);
    chk("s4b_sum", 64'(sum), 64'h5);
    chk("s4b_ovf", 64'(overflow), 64'd0);
    chk("s4b_busy", 64'(busy_cnt), 64'd4);

    load(32'h1, 32'h2);
    run_op(4'd0, 5'd16, 4'd0, 3);
    chk("s5_sum", 64'(sum), 64'h88);
    chk("s5_mem0", 64'(mem[0]), 64'h88);
    chk("s5_busy", 64'(busy_cnt), 64'd19);
    chk("s5_done_cnt", 64'(done_cnt), 64'd1);
    chk("s5_we_cnt", 64'(we_cnt), 64'd1);
    chk("s5_mem3", 64'(mem[3]), 64'd4);

    load(32'h1, 32'h2);
    we_cnt = 0;
    @(negedge clk);
    src_addr = 4'd0;
    len      = 5'd8;
    dst_addr = 4'd10;
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    if (ram_we) we_cnt++;
    @(posedge clk);
    @(negedge clk);
    chk("s6_busy_pre", 64'(busy), 64'd1);
    chk("s6_raddr_pre", 64'(ram_read_addr), 64'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("s6_rst_busy", 64'(busy), 64'd0);
    chk("s6_rst_sum", 64'(sum), 64'd0);
    chk("s6_rst_raddr", 64'(ram_read_addr), 64'd0);
    chk("s6_rst_we", 64'(ram_we), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      if (ram_we) we_cnt++;
    end
    chk("s6_we_never", 64'(we_cnt), 64'd0);
    chk("s6_mem10", 64'(mem[10]), 64'd11);
    run_op(4'd0, 5'd3, 4'd12, -1);
    chk("s6b_sum", 64'(sum), 64'h6);
    chk("s6b_mem12", 64'(mem[12]), 64'h6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
